alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues ALU opcodes as registered one-hot enables.
// Single-cycle ops (0..5, 8..N_OPS-1) produce their enable one cycle after acceptance.
// mul (6) and div (7) raise a start pulse, hold the sequencer busy, then emit one completion cycle.
// Optional feature: define ALU_OP_ILLEGAL_TRAP_EN to add the sticky `illegal` output.
module alu_op_sequencer #(
  parameter int unsigned OPCODE_W      = 5,
  parameter int unsigned N_OPS         = 8,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
  input  logic                flush,
  output logic [N_OPS-1:0]    enable_wires,
  output logic                out_valid,
  output logic                ctrl_MULT,
  output logic                ctrl_DIV,
  output logic                data_resultRDY,
  output logic                busy
`ifdef ALU_OP_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  localparam logic [7:0]  CntLoad = 8'(MULDIV_CYCLES - 1);
  localparam int unsigned OpMul   = 6;
  localparam int unsigned OpDiv   = 7;

  typedef enum logic [1:0] {StIdle, StBusyMul, StBusyDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_OPS-1:0] en_q, en_d;
  logic             ov_q, ov_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             rdy_q, rdy_d;

  logic [31:0]      op_idx;
  logic             accept;
  logic             supported;
  logic             hot_en;
  int unsigned      hot_idx;

  assign op_idx    = 32'(ctrl_ALUopcode);
  assign in_ready  = (state_q == StIdle) && !flush;
  assign accept    = in_valid && in_ready;
  assign supported = op_idx < N_OPS;

  // Next-state, counter and registered-output decode; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = 1'b0;
    div_d   = 1'b0;
    rdy_d   = 1'b0;
    hot_en  = 1'b0;
    hot_idx = 0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (op_idx == OpMul) begin
              state_d = StBusyMul;
              cnt_d   = CntLoad;
              mult_d  = 1'b1;
            end else if (op_idx == OpDiv) begin
              state_d = StBusyDiv;
              cnt_d   = CntLoad;
              div_d   = 1'b1;
            end else if (supported) begin
              hot_en  = 1'b1;
              hot_idx = op_idx;
            end
          end
        end
        StBusyMul, StBusyDiv: begin
          if (cnt_q == 8'd0) begin
            state_d = StDone;
            rdy_d   = 1'b1;
            hot_en  = 1'b1;
            hot_idx = (state_q == StBusyMul) ? OpMul : OpDiv;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    // Enable is only ever nonzero together with out_valid.
    ov_d = hot_en;
    for (int unsigned i = 0; i < N_OPS; i++) begin
      en_d[i] = hot_en && (i == hot_idx);
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      en_q    <= '0;
      ov_q    <= 1'b0;
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ov_q    <= ov_d;
      mult_q  <= mult_d;
      div_q   <= div_d;
      rdy_q   <= rdy_d;
    end
  end

  assign enable_wires   = en_q;
  assign out_valid      = ov_q;
  assign ctrl_MULT      = mult_q;
  assign ctrl_DIV       = div_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != StIdle);

`ifdef ALU_OP_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap on an accepted unsupported opcode; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (accept && !supported) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic, all checked each cycle
// against a cycle-count model (acceptance time -> busy window end / result time).
module tb_alu_op_sequencer;

  localparam int unsigned OPCODE_W      = 5;
  localparam int unsigned N_OPS         = 8;
  localparam int unsigned MULDIV_CYCLES = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [OPCODE_W-1:0] ctrl_ALUopcode = '0;
  logic                flush = 1'b0;
  logic [N_OPS-1:0]    enable_wires;
  logic                out_valid;
  logic                ctrl_MULT;
  logic                ctrl_DIV;
  logic                data_resultRDY;
  logic                busy;
`ifdef ALU_OP_ILLEGAL_TRAP_EN
  logic                illegal;
`endif

  alu_op_sequencer #(
    .OPCODE_W      (OPCODE_W),
    .N_OPS         (N_OPS),
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .flush          (flush),
    .enable_wires   (enable_wires),
    .out_valid      (out_valid),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef ALU_OP_ILLEGAL_TRAP_EN
    ,
    .illegal        (illegal)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: everything is expressed as absolute cycle numbers.
  int cyc        = 0;
  int busy_end   = -1;  // last cycle in which the sequencer refuses new opcodes
  int result_cyc = -1;  // cycle in which the mul/div completion is visible
  int result_op  = 0;
  int illegal_m  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_illegal(input int exp);
`ifdef ALU_OP_ILLEGAL_TRAP_EN
    chk("illegal", 32'(illegal), 32'(exp));
`else
    if (exp < 0) $display("unreachable");
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_enable_wires"}, 32'(enable_wires), 0);
    chk({tag, "_ctrl_MULT"}, 32'(ctrl_MULT), 0);
    chk({tag, "_ctrl_DIV"}, 32'(ctrl_DIV), 0);
    chk({tag, "_data_resultRDY"}, 32'(data_resultRDY), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One clock cycle: drive, check in_ready, advance the model, check registered outputs.
  task automatic step(input int v, input int op, input int fl);
    int exp_ready, acc, nxt;
    int exp_ov, exp_en, exp_mul, exp_div, exp_rdy, exp_busy;
    in_valid       = (v != 0);
    ctrl_ALUopcode = OPCODE_W'(op);
    flush          = (fl != 0);
    #1;
    exp_ready = (fl == 0 && cyc > busy_end) ? 1 : 0;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = (v != 0 && exp_ready != 0) ? 1 : 0;
    nxt = cyc + 1;
    exp_ov = 0; exp_en = 0; exp_mul = 0; exp_div = 0; exp_rdy = 0;
    if (fl != 0) begin
      if (result_cyc > cyc) result_cyc = -1;
      if (busy_end > cyc) busy_end = cyc;
    end else if (acc != 0) begin
      if (op == 6 || op == 7) begin
        busy_end   = cyc + MULDIV_CYCLES + 1;
        result_cyc = busy_end;
        result_op  = op;
        exp_mul    = (op == 6) ? 1 : 0;
        exp_div    = (op == 7) ? 1 : 0;
      end else if (op < N_OPS) begin
        exp_ov = 1;
        exp_en = 1 << op;
      end else begin
        illegal_m = 1;
      end
    end
    if (result_cyc == nxt) begin
      exp_ov  = 1;
      exp_en  = 1 << result_op;
      exp_rdy = 1;
    end
    exp_busy = (nxt <= busy_end) ? 1 : 0;
    @(posedge clock);
    #1;
    cyc = nxt;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("enable_wires", 32'(enable_wires), 32'(exp_en));
    chk("ctrl_MULT", 32'(ctrl_MULT), 32'(exp_mul));
    chk("ctrl_DIV", 32'(ctrl_DIV), 32'(exp_div));
    chk("data_resultRDY", 32'(data_resultRDY), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk_illegal(illegal_m);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    #1;
    chk_quiet("rst_async");
    chk_illegal(0);
    @(posedge clock);
    #1;
    cyc++;
    chk_quiet("rst_held");
    reset      = 1'b1;
    busy_end   = -1;
    result_cyc = -1;
    illegal_m  = 0;
  endtask

  initial begin
    int op, r;
    #1;
    chk_quiet("por");
    chk_illegal(0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // In-ready right after release, then ops 0..5 back to back.
    for (int i = 0; i < 6; i++) step(1, i, 0);
    step(0, 0, 0);

    // Multiply: full busy window and completion.
    step(1, 6, 0);
    repeat (MULDIV_CYCLES + 2) step(0, 0, 0);

    // Divide aborted by flush at +10, opcode 0 accepted at +11.
    step(1, 7, 0);
    repeat (9) step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    // Flush wins over a simultaneous in_valid.
    step(1, 3, 1);
    step(0, 0, 0);

    // Multiply dropped by reset at +5; no late completion.
    step(1, 6, 0);
    repeat (4) step(0, 0, 0);
    pulse_reset();
    repeat (40) step(0, 0, 0);

    // Unsupported opcode; trap (if built) survives a flush.
    step(1, 9, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Opcode 2 held during a divide; accepted only once idle.
    step(1, 7, 0);
    for (int i = 0; i < 100 && cyc <= busy_end; i++) step(1, 2, 0);
    step(1, 2, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Random traffic, including unsupported opcodes and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) op = 6 + int'($urandom_range(0, 1));
      else begin
        op = int'($urandom_range(0, 9));
        if (op >= 6) op = op + 2;
      end
      step(($urandom_range(0, 9) < 7) ? 1 : 0, op,
           ($urandom_range(0, 29) == 0) ? 1 : 0);
    end

    pulse_reset();
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
